// File: rtl/ex_mem_stage_pkg.sv
// Shared types and constants for the EX->MEM pipeline register.
package ex_mem_stage_pkg;

    typedef enum logic {
        ST_RUN       = 1'b0,
        ST_TRAP_WAIT = 1'b1
    } state_e;

    localparam logic [4:0] EXC_OV = 5'h0C;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

endpackage

// File: rtl/ex_mem_stage_sat_counter.sv
// Saturating event counter; freezes while hold is high.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         hold,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!hold && inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with precise overflow trap,
// squash window until the exception controller acknowledges.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ex_valid,
    input  logic [DATA_W-1:0]  ex_pc,
    input  logic [DATA_W-1:0]  ex_alu_r,
    input  logic               ex_z,
    input  logic               ex_v,
    input  logic               ex_n,
    input  logic               ex_trap_ov,
    input  logic [DATA_W-1:0]  ex_st_data,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic               ex_reg_write,
    input  logic               ex_mem_read,
    input  logic               ex_mem_write,
    input  logic [1:0]         ex_mem_to_reg,
    input  logic               mem_stall,
    input  logic               flush,
    input  logic               exc_ack,
    output logic               mem_valid,
    output logic [DATA_W-1:0]  mem_pc,
    output logic [DATA_W-1:0]  mem_alu_r,
    output logic [DATA_W-1:0]  mem_st_data,
    output logic               mem_z,
    output logic               mem_v,
    output logic               mem_n,
    output logic [RADDR_W-1:0] mem_rd,
    output logic               mem_reg_write,
    output logic               mem_mem_read,
    output logic               mem_mem_write,
    output logic [1:0]         mem_mem_to_reg,
    output logic               exc_req,
    output logic [DATA_W-1:0]  exc_epc,
    output logic [CNT_W-1:0]   ov_count
);

    state_e state_q, state_d;

    logic accept;
    logic trap_hit;
    logic pass;
    logic valid_q, rw_q, mr_q, mw_q;
    logic req_q;

    assign accept   = !mem_stall;
    assign trap_hit = accept && !flush && (state_q == ST_RUN)
                    && ex_valid && ex_trap_ov && ex_v;
    assign pass     = (state_q == ST_RUN) && !trap_hit && !flush;

    // Flush never moves the FSM; only a trap or an ack does.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            unique case (state_q)
                ST_RUN:       if (trap_hit) state_d = ST_TRAP_WAIT;
                ST_TRAP_WAIT: if (exc_ack)  state_d = ST_RUN;
                default:      state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush clears the enables even when MEM is stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
        end else if (accept) begin
            valid_q <= pass && ex_valid;
            rw_q    <= pass && ex_valid && ex_reg_write;
            mr_q    <= pass && ex_valid && ex_mem_read;
            mw_q    <= pass && ex_valid && ex_mem_write;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_pc         <= '0;
            mem_alu_r      <= '0;
            mem_st_data    <= '0;
            mem_z          <= 1'b0;
            mem_v          <= 1'b0;
            mem_n          <= 1'b0;
            mem_rd         <= '0;
            mem_mem_to_reg <= WB_ALU;
        end else if (accept) begin
            mem_pc         <= ex_pc;
            mem_alu_r      <= ex_alu_r;
            mem_st_data    <= ex_st_data;
            mem_z          <= ex_z;
            mem_v          <= ex_v;
            mem_n          <= ex_n;
            mem_rd         <= ex_rd;
            mem_mem_to_reg <= ex_mem_to_reg;
        end
    end

    // A request caught by a stall is held and shown once MEM frees up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q   <= 1'b0;
            exc_epc <= '0;
        end else if (accept) begin
            req_q <= trap_hit;
            if (trap_hit) exc_epc <= ex_pc;
        end
    end

    sat_counter #(.W(CNT_W)) u_ov_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (trap_hit),
        .hold  (mem_stall),
        .count (ov_count)
    );

    assign mem_valid     = valid_q;
    assign mem_reg_write = rw_q && valid_q;
    assign mem_mem_read  = mr_q && valid_q;
    assign mem_mem_write = mw_q && valid_q;
    assign exc_req       = req_q && !mem_stall;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scenario bench for ex_mem_stage with a queue of expected MEM outputs.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_z, ex_v, ex_n, ex_trap_ov;
    logic [31:0] ex_pc, ex_alu_r, ex_st_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic [1:0]  ex_mem_to_reg;
    logic        mem_stall, flush, exc_ack;
    logic        mem_valid, mem_z, mem_v, mem_n;
    logic [31:0] mem_pc, mem_alu_r, mem_st_data, exc_epc;
    logic [4:0]  mem_rd;
    logic        mem_reg_write, mem_mem_read, mem_mem_write;
    logic [1:0]  mem_mem_to_reg;
    logic        exc_req;
    logic [7:0]  ov_count;

    typedef struct {
        logic        valid;
        logic [31:0] r;
        logic [4:0]  rd;
        logic        rw;
        logic        v;
        logic        req;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] cnt_model = 8'd0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_r(ex_alu_r),
        .ex_z(ex_z), .ex_v(ex_v), .ex_n(ex_n), .ex_trap_ov(ex_trap_ov),
        .ex_st_data(ex_st_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .mem_stall(mem_stall), .flush(flush), .exc_ack(exc_ack),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_alu_r(mem_alu_r),
        .mem_st_data(mem_st_data), .mem_z(mem_z), .mem_v(mem_v),
        .mem_n(mem_n), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_mem_to_reg(mem_mem_to_reg), .exc_req(exc_req),
        .exc_epc(exc_epc), .ov_count(ov_count)
    );

    task automatic drive(input logic val, input logic [31:0] pc,
                         input logic [31:0] r, input logic v,
                         input logic trap, input logic [4:0] rd,
                         input logic rw);
        ex_valid = val; ex_pc = pc; ex_alu_r = r; ex_v = v;
        ex_trap_ov = trap; ex_rd = rd; ex_reg_write = rw;
        ex_z = 1'b0; ex_n = 1'b0; ex_st_data = '0;
        ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_mem_to_reg = 2'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; mem_stall = 1'b0; flush = 1'b0; exc_ack = 1'b0;
        drive(1'b1, 32'h10, 32'h55, 1'b1, 1'b1, 5'd7, 1'b1);
        repeat (2) step();
        checks++;
        if ({mem_valid, mem_reg_write, exc_req} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl got=%b want=000",
                     {mem_valid, mem_reg_write, exc_req});
        end
        checks++;
        if ({mem_alu_r, mem_pc, exc_epc, ov_count} !== '0) begin
            errors++;
            $display("FAIL reset_data r=%h epc=%h cnt=%h want 0",
                     mem_alu_r, exc_epc, ov_count);
        end
        drive(1'b0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        step();
    endtask

    task automatic test_pass_through();
        drive(1'b1, 32'h0040_0000, 32'h0000_0005, 1'b0, 1'b0, 5'd3, 1'b1);
        ex_z = 1'b1; ex_n = 1'b1; ex_st_data = 32'hCAFE_0001;
        ex_mem_read = 1'b1; ex_mem_to_reg = 2'd1;
        exp_q.push_back('{1'b1, 32'h5, 5'd3, 1'b1, 1'b0, 1'b0});
        step();
        e = exp_q.pop_front();
        checks++;
        if (mem_valid !== e.valid || mem_alu_r !== e.r ||
            mem_rd !== e.rd || mem_reg_write !== e.rw ||
            exc_req !== e.req) begin
            errors++;
            $display("FAIL pass got v=%b r=%h rd=%0d rw=%b req=%b want %b %h %0d %b %b",
                     mem_valid, mem_alu_r, mem_rd, mem_reg_write, exc_req,
                     e.valid, e.r, e.rd, e.rw, e.req);
        end
        checks++;
        if ({mem_z, mem_n, mem_mem_read, mem_mem_write} !== 4'b1110 ||
            mem_st_data !== 32'hCAFE_0001 || mem_mem_to_reg !== 2'd1 ||
            mem_pc !== 32'h0040_0000) begin
            errors++;
            $display("FAIL pass_fields znrw=%b sd=%h m2r=%0d pc=%h",
                     {mem_z, mem_n, mem_mem_read, mem_mem_write},
                     mem_st_data, mem_mem_to_reg, mem_pc);
        end
    endtask

    task automatic test_overflow_trap();
        drive(1'b1, 32'h0040_0010, 32'h8000_0000, 1'b1, 1'b1, 5'd4, 1'b1);
        exp_q.push_back('{1'b0, 32'h8000_0000, 5'd4, 1'b0, 1'b1, 1'b1});
        cnt_model = 8'd1;
        step();
        e = exp_q.pop_front();
        checks++;
        if (mem_valid !== e.valid || mem_reg_write !== e.rw ||
            exc_req !== e.req) begin
            errors++;
            $display("FAIL trap got v=%b rw=%b req=%b want %b %b %b",
                     mem_valid, mem_reg_write, exc_req, e.valid, e.rw, e.req);
        end
        checks++;
        if (exc_epc !== 32'h0040_0010 || ov_count !== cnt_model) begin
            errors++;
            $display("FAIL trap_epc epc=%h cnt=%0d want 00400010 %0d",
                     exc_epc, ov_count, cnt_model);
        end
        drive(1'b0, 0, 0, 0, 0, 0, 0);
        step();
        checks++;
        if (exc_req !== 1'b0) begin
            errors++;
            $display("FAIL trap_pulse got=%b want=0", exc_req);
        end
    endtask

    task automatic test_squash_window();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + 32'(i*4), 32'(i + 1), 1'b0, 1'b0,
                  5'(i + 1), 1'b1);
            exp_q.push_back('{1'b0, 32'(i + 1), 5'(i + 1), 1'b0, 1'b0, 1'b0});
            step();
            e = exp_q.pop_front();
            checks++;
            if (mem_valid !== e.valid || mem_reg_write !== e.rw ||
                exc_req !== e.req) begin
                errors++;
                $display("FAIL squash%0d v=%b rw=%b req=%b want %b %b %b", i,
                         mem_valid, mem_reg_write, exc_req,
                         e.valid, e.rw, e.req);
            end
        end
        drive(1'b0, 0, 0, 0, 0, 0, 0);
        exc_ack = 1'b1;
        step();
        exc_ack = 1'b0;
        drive(1'b1, 32'h110, 32'h44, 1'b0, 1'b0, 5'd9, 1'b1);
        exp_q.push_back('{1'b1, 32'h44, 5'd9, 1'b1, 1'b0, 1'b0});
        step();
        e = exp_q.pop_front();
        checks++;
        if (mem_valid !== e.valid || mem_alu_r !== e.r ||
            mem_rd !== e.rd || mem_reg_write !== e.rw) begin
            errors++;
            $display("FAIL after_ack v=%b r=%h rd=%0d rw=%b want %b %h %0d %b",
                     mem_valid, mem_alu_r, mem_rd, mem_reg_write,
                     e.valid, e.r, e.rd, e.rw);
        end
    endtask

    task automatic test_stall_flush();
        drive(1'b1, 32'h200, 32'hAA, 1'b0, 1'b0, 5'd5, 1'b1);
        step();
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300, 32'h1234 + 32'(i), 1'b0, 1'b0, 5'd6, 1'b0);
            step();
            checks++;
            if (mem_valid !== 1'b1 || mem_alu_r !== 32'hAA ||
                mem_rd !== 5'd5 || mem_reg_write !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d v=%b r=%h rd=%0d want 1 aa 5",
                         i, mem_valid, mem_alu_r, mem_rd);
            end
        end
        flush = 1'b1;
        step();
        checks++;
        if (mem_valid !== 1'b0 || mem_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL stall_flush v=%b rw=%b want 0 0",
                     mem_valid, mem_reg_write);
        end
        mem_stall = 1'b0;
        drive(1'b1, 32'h400, 32'h8000_0000, 1'b1, 1'b1, 5'd2, 1'b1);
        step();
        checks++;
        if (exc_req !== 1'b0 || ov_count !== cnt_model || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL trap_flush req=%b cnt=%0d v=%b want 0 %0d 0",
                     exc_req, ov_count, mem_valid, cnt_model);
        end
        flush = 1'b0;
        mem_stall = 1'b1;
        step();
        checks++;
        if (exc_req !== 1'b0 || ov_count !== cnt_model) begin
            errors++;
            $display("FAIL trap_stall req=%b cnt=%0d want 0 %0d",
                     exc_req, ov_count, cnt_model);
        end
        mem_stall = 1'b0;
        cnt_model = cnt_model + 8'd1;
        step();
        checks++;
        if (exc_req !== 1'b1 || ov_count !== cnt_model ||
            exc_epc !== 32'h400) begin
            errors++;
            $display("FAIL trap_after_stall req=%b cnt=%0d epc=%h want 1 %0d 400",
                     exc_req, ov_count, exc_epc, cnt_model);
        end
        drive(1'b0, 0, 0, 0, 0, 0, 0);
        exc_ack = 1'b1;
        step();
        exc_ack = 1'b0;
    endtask

    task automatic test_unsigned_overflow();
        drive(1'b1, 32'h500, 32'h0000_0000, 1'b1, 1'b0, 5'd8, 1'b1);
        ex_z = 1'b1;
        exp_q.push_back('{1'b1, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0});
        step();
        e = exp_q.pop_front();
        checks++;
        if (mem_valid !== e.valid || mem_v !== e.v || mem_z !== 1'b1 ||
            exc_req !== e.req || mem_reg_write !== e.rw ||
            ov_count !== cnt_model) begin
            errors++;
            $display("FAIL addu v=%b mv=%b z=%b req=%b rw=%b cnt=%0d",
                     mem_valid, mem_v, mem_z, exc_req, mem_reg_write, ov_count);
        end
    endtask

    task automatic test_saturation_reset();
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 32'h600, 32'h8000_0000, 1'b1, 1'b1, 5'd1, 1'b1);
            if (cnt_model != 8'hFF) cnt_model = cnt_model + 8'd1;
            step();
            drive(1'b0, 0, 0, 0, 0, 0, 0);
            exc_ack = 1'b1;
            step();
            exc_ack = 1'b0;
        end
        checks++;
        if (ov_count !== 8'hFF || cnt_model !== 8'hFF) begin
            errors++;
            $display("FAIL saturate cnt=%h want ff", ov_count);
        end
        drive(1'b1, 32'h0777_0000, 32'h8000_0000, 1'b1, 1'b1, 5'd1, 1'b1);
        step();
        drive(1'b0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (exc_req !== 1'b1 || ov_count !== 8'hFF ||
            exc_epc !== 32'h0777_0000) begin
            errors++;
            $display("FAIL sat_trap req=%b cnt=%h epc=%h want 1 ff 07770000",
                     exc_req, ov_count, exc_epc);
        end
        step();
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({mem_valid, exc_req, exc_epc, ov_count, mem_alu_r} !== '0) begin
            errors++;
            $display("FAIL async_reset v=%b req=%b epc=%h cnt=%h r=%h",
                     mem_valid, exc_req, exc_epc, ov_count, mem_alu_r);
        end
        step();
        reset = 1'b1;
        drive(1'b1, 32'h800, 32'h99, 1'b0, 1'b0, 5'd10, 1'b1);
        exp_q.push_back('{1'b1, 32'h99, 5'd10, 1'b1, 1'b0, 1'b0});
        step();
        e = exp_q.pop_front();
        checks++;
        if (mem_valid !== e.valid || mem_alu_r !== e.r ||
            mem_rd !== e.rd || mem_reg_write !== e.rw) begin
            errors++;
            $display("FAIL post_reset v=%b r=%h rd=%0d rw=%b want %b %h %0d %b",
                     mem_valid, mem_alu_r, mem_rd, mem_reg_write,
                     e.valid, e.r, e.rd, e.rw);
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_overflow_trap();
        test_squash_window();
        test_stall_flush();
        test_unsigned_overflow();
        test_saturation_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
